atm_account_server: RTL and testbench
=====================================

# atm_account_server

Account-database responder for the ATM datapath. Accepts one request at a time from the ATM front-end controller: PIN verify, balance query, deposit, withdraw or logout. Answers each request with a status code and the resulting balance. Owns the per-card PIN, balance, failed-attempt and lock storage, plus the single authenticated-session register, so the front-end FSM holds no account state.

## Interface
- NUM_ACCOUNTS, 6: table depth; valid card IDs are 1..NUM_ACCOUNTS-1, ID 0 is invalid
- BAL_W, 32: balance and amount width
- MAX_TRIES, 3: consecutive bad PINs that lock a card

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  3  000 VERIFY, 001 BALANCE, 010 DEPOSIT, 011 WITHDRAW, 100 LOGOUT, others illegal
- req_card  in  4  card ID
- req_pin  in  16  PIN digits, [15:12]=PIN3 … [3:0]=PIN0
- req_amount  in  BAL_W  deposit/withdraw amount
- rsp_valid  out  1  response present
- rsp_ready  in  1  front-end consumes response
- rsp_status  out  3  0 OK, 1 BAD_CARD, 2 BAD_PIN, 3 LOCKED, 4 NO_FUNDS, 5 OVERFLOW, 6 NOT_AUTH, 7 BAD_REQ
- rsp_balance  out  BAL_W  balance per rules below

## Operation
- **Reset** (rst high at an edge):
  - Every account i in 1..NUM_ACCOUNTS-1 loads PIN digits all = i and balance = i*1111.
  - Fail counters and locks clear; the session is cleared.
  - State goes to IDLE; req_ready=1, rsp_valid=0, rsp_status=0, rsp_balance=0.
- **FSM:** IDLE → LOOKUP → EXEC → RESP → IDLE.
  - IDLE: req_valid&&req_ready at an edge captures op, card, pin and amount into registers and moves to LOOKUP. Inputs are ignored at all other times.
  - LOOKUP: reads the account entry and computes the status.
  - EXEC: commits the table/session update and registers the response.
  - RESP: rsp_valid=1, fields held stable until rsp_ready is high at an edge, then IDLE.
- **Check order, first hit wins:**
  1. Illegal op → BAD_REQ.
  2. LOGOUT → clear session, OK, no card check.
  3. Card 0 or ≥NUM_ACCOUNTS → BAD_CARD.
  4. Card locked → LOCKED.
  5. Op-specific rules below.
- **VERIFY:**
  - Always clears the session first.
  - Correct PIN (all four digits match) → OK, session = card, fail counter = 0.
  - Wrong PIN → BAD_PIN, counter +1; reaching MAX_TRIES sets the lock. That request still returns BAD_PIN; later requests on the card return LOCKED.
  - A VERIFY on a locked card returns LOCKED and does not touch the counter.
- **BALANCE/DEPOSIT/WITHDRAW:**
  - Session ≠ card → NOT_AUTH.
  - DEPOSIT/WITHDRAW with amount 0 → BAD_REQ.
  - DEPOSIT: BAL_W-bit add with carry out; carry set → OVERFLOW, balance unchanged; else OK with the new balance.
  - WITHDRAW: amount > balance → NO_FUNDS, unchanged. Amount == balance is allowed and leaves 0.
- **rsp_balance:**
  - Post-operation balance for OK on BALANCE/DEPOSIT/WITHDRAW.
  - Current balance for NO_FUNDS/OVERFLOW.
  - 0 for every other case.
- Only the failed op's own status is reported; no partial updates, ever.

## Timing
- Request accepted at edge N. Table/session updated at edge N+2. rsp_valid visible after edge N+2.
- rsp_valid clears at the first edge with rsp_ready=1; req_ready is high again after that edge.
- Minimum 4 cycles per transaction with rsp_ready tied high.
- req_ready is 0 in LOOKUP/EXEC/RESP; req_valid there is ignored and the front-end must hold it.
- rsp_ready while rsp_valid=0 has no effect.
- Reset mid-transaction: the request is discarded and rsp_valid=0 after the edge. Any update not yet committed is lost; committed updates are overwritten by re-initialisation.
- Reset has priority over every other event at the same edge.

## Test plan
- Reset, VERIFY card 3 PIN 3333 → OK, balance 0. Then BALANCE card 3 → OK, 3333, rsp_valid exactly 2 cycles after accept.
- After VERIFY card 2 OK:
  - DEPOSIT 100 → OK, 2322.
  - WITHDRAW 2322 → OK, 0.
  - WITHDRAW 1 → NO_FUNDS, 0.
  - DEPOSIT 0 → BAD_REQ, 0.
- Three VERIFY card 4 PIN 0000 → BAD_PIN ×3. VERIFY card 4 PIN 4444 → LOCKED. A new reset restores OK.
- BALANCE card 1 without verify → NOT_AUTH.
- VERIFY card 1 OK then LOGOUT → OK; BALANCE card 1 → NOT_AUTH.
- Card 0 VERIFY → BAD_CARD; card 7 → BAD_CARD; op 101 → BAD_REQ.
- After a card-5 session with balance forced to 0xFFFF_FFF0, DEPOSIT 0x20 → OVERFLOW, balance 0xFFFF_FFF0.
- Back-pressure: hold rsp_ready=0 for 5 cycles → rsp fields stable, req_ready=0.
- Reset asserted in EXEC → rsp_valid=0, card 3 balance 3333.

Source files
------------

// File: rtl/atm_account_server_if.sv
// Request/response handshake bundle between the ATM front-end controller and the account server.
interface atm_account_server_if #(
  parameter int BAL_W = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [3:0]       req_card;
  logic [15:0]      req_pin;
  logic [BAL_W-1:0] req_amount;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_status;
  logic [BAL_W-1:0] rsp_balance;

  modport master (
    output req_valid, req_op, req_card, req_pin, req_amount, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_balance
  );

  modport slave (
    input  req_valid, req_op, req_card, req_pin, req_amount, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_balance
  );
endinterface

// File: rtl/atm_account_server.sv
// Account database for the ATM datapath: owns PINs, balances, fail counters, locks and the session,
// and answers one request at a time through an IDLE -> LOOKUP -> EXEC -> RESP sequence.
module atm_account_server #(
  parameter int NUM_ACCOUNTS = 6,
  parameter int BAL_W        = 32,
  parameter int MAX_TRIES    = 3
) (
  input logic                 clk,
  input logic                 rst,
  atm_account_server_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ACCOUNTS);
  localparam int CNT_W = $clog2(MAX_TRIES + 1);

  localparam logic [2:0] OP_VERIFY   = 3'd0;
  localparam logic [2:0] OP_BALANCE  = 3'd1;
  localparam logic [2:0] OP_DEPOSIT  = 3'd2;
  localparam logic [2:0] OP_LOGOUT   = 3'd4;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_BAD_CARD = 3'd1;
  localparam logic [2:0] ST_BAD_PIN  = 3'd2;
  localparam logic [2:0] ST_LOCKED   = 3'd3;
  localparam logic [2:0] ST_NO_FUNDS = 3'd4;
  localparam logic [2:0] ST_OVERFLOW = 3'd5;
  localparam logic [2:0] ST_NOT_AUTH = 3'd6;
  localparam logic [2:0] ST_BAD_REQ  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EXEC, S_RESP} state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [3:0]       card_q;
  logic [15:0]      pin_q;
  logic [BAL_W-1:0] amount_q;
  logic [3:0]       session_q;

  logic [15:0]      pinTab_q  [NUM_ACCOUNTS];
  logic [BAL_W-1:0] balTab_q  [NUM_ACCOUNTS];
  logic [CNT_W-1:0] failTab_q [NUM_ACCOUNTS];
  logic             lockTab_q [NUM_ACCOUNTS];

  logic [2:0]       status_q, status_d;
  logic [BAL_W-1:0] rspBal_q, rspBal_d;
  logic             wrBal_q, wrBal_d;
  logic             clrSess_q, clrSess_d;
  logic             setSess_q, setSess_d;
  logic             failInc_q, failInc_d;
  logic             failClr_q, failClr_d;
  logic             setLock_q, setLock_d;

  logic             reqReady_q, rspValid_q;
  logic [2:0]       rspStatus_q;
  logic [BAL_W-1:0] rspBalance_q;

  logic             cardOk;
  logic [IDX_W-1:0] idx;
  logic [BAL_W-1:0] curBal;
  logic [CNT_W-1:0] failNext;
  logic [BAL_W:0]   sum;

  assign cardOk   = (card_q != 4'd0) && (card_q < 4'(NUM_ACCOUNTS));
  assign idx      = cardOk ? card_q[IDX_W-1:0] : '0;
  assign curBal   = balTab_q[idx];
  assign failNext = failTab_q[idx] + CNT_W'(1);
  assign sum      = {1'b0, curBal} + {1'b0, amount_q};

  // Decide outcome and pending table/session updates; the first rule that hits wins.
  always_comb begin
    status_d  = ST_OK;
    rspBal_d  = '0;
    wrBal_d   = 1'b0;
    clrSess_d = 1'b0;
    setSess_d = 1'b0;
    failInc_d = 1'b0;
    failClr_d = 1'b0;
    setLock_d = 1'b0;
    if (op_q > OP_LOGOUT) begin
      status_d = ST_BAD_REQ;
    end else if (op_q == OP_LOGOUT) begin
      clrSess_d = 1'b1;
    end else if (!cardOk) begin
      status_d = ST_BAD_CARD;
    end else if (lockTab_q[idx]) begin
      status_d = ST_LOCKED;
    end else if (op_q == OP_VERIFY) begin
      clrSess_d = 1'b1;
      if (pin_q == pinTab_q[idx]) begin
        setSess_d = 1'b1;
        failClr_d = 1'b1;
      end else begin
        status_d  = ST_BAD_PIN;
        failInc_d = 1'b1;
        setLock_d = (failNext >= CNT_W'(MAX_TRIES));
      end
    end else if (session_q != card_q) begin
      status_d = ST_NOT_AUTH;
    end else if (op_q != OP_BALANCE && amount_q == '0) begin
      status_d = ST_BAD_REQ;
    end else if (op_q == OP_BALANCE) begin
      rspBal_d = curBal;
    end else if (op_q == OP_DEPOSIT) begin
      if (sum[BAL_W]) begin
        status_d = ST_OVERFLOW;
        rspBal_d = curBal;
      end else begin
        wrBal_d  = 1'b1;
        rspBal_d = sum[BAL_W-1:0];
      end
    end else if (amount_q > curBal) begin
      status_d = ST_NO_FUNDS;
      rspBal_d = curBal;
    end else begin
      wrBal_d  = 1'b1;
      rspBal_d = curBal - amount_q;
    end
  end

  // Single sequencer; a successful op's response balance doubles as the value written back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      card_q       <= '0;
      pin_q        <= '0;
      amount_q     <= '0;
      session_q    <= '0;
      status_q     <= '0;
      rspBal_q     <= '0;
      wrBal_q      <= 1'b0;
      clrSess_q    <= 1'b0;
      setSess_q    <= 1'b0;
      failInc_q    <= 1'b0;
      failClr_q    <= 1'b0;
      setLock_q    <= 1'b0;
      reqReady_q   <= 1'b1;
      rspValid_q   <= 1'b0;
      rspStatus_q  <= '0;
      rspBalance_q <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pinTab_q[i]  <= {4{i[3:0]}};
        balTab_q[i]  <= BAL_W'(i * 1111);
        failTab_q[i] <= '0;
        lockTab_q[i] <= 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && reqReady_q) begin
            op_q       <= bus.req_op;
            card_q     <= bus.req_card;
            pin_q      <= bus.req_pin;
            amount_q   <= bus.req_amount;
            reqReady_q <= 1'b0;
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          status_q  <= status_d;
          rspBal_q  <= rspBal_d;
          wrBal_q   <= wrBal_d;
          clrSess_q <= clrSess_d;
          setSess_q <= setSess_d;
          failInc_q <= failInc_d;
          failClr_q <= failClr_d;
          setLock_q <= setLock_d;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          if (setSess_q) session_q <= card_q;
          else if (clrSess_q) session_q <= '0;
          if (failClr_q) failTab_q[idx] <= '0;
          else if (failInc_q) failTab_q[idx] <= failNext;
          if (setLock_q) lockTab_q[idx] <= 1'b1;
          if (wrBal_q) balTab_q[idx] <= rspBal_q;
          rspValid_q   <= 1'b1;
          rspStatus_q  <= status_q;
          rspBalance_q <= rspBal_q;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rspValid_q <= 1'b0;
            reqReady_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = reqReady_q;
  assign bus.rsp_valid   = rspValid_q;
  assign bus.rsp_status  = rspStatus_q;
  assign bus.rsp_balance = rspBalance_q;
endmodule

// File: tb/tb_atm_account_server.sv
// Randomised and directed bench for atm_account_server, checked against an account-level model.
module tb_atm_account_server;
  localparam int BAL_W = 32;

  logic clk = 1'b0;
  logic rst;

  atm_account_server_if #(.BAL_W(BAL_W)) bus();

  atm_account_server #(
    .NUM_ACCOUNTS(6),
    .BAL_W(BAL_W),
    .MAX_TRIES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  longint modelBal[6];
  int     modelFails[6];
  bit     modelLock[6];
  int     modelSession;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 6; i++) begin
      modelBal[i]   = longint'(i) * 1111;
      modelFails[i] = 0;
      modelLock[i]  = 1'b0;
    end
    modelSession = 0;
  endtask

  // Account-level behaviour: what the customer should see and what the bank should remember.
  task automatic modelStep(input logic [2:0] op, input logic [3:0] card, input logic [15:0] pin,
                           input logic [31:0] amount, output logic [2:0] st, output logic [31:0] bal);
    int c;
    bit pinOk;
    c   = int'(card);
    st  = 3'd0;
    bal = 32'd0;
    if (op > 3'd4) st = 3'd7;
    else if (op == 3'd4) modelSession = 0;
    else if (c == 0 || c >= 6) st = 3'd1;
    else if (modelLock[c]) st = 3'd3;
    else if (op == 3'd0) begin
      modelSession = 0;
      pinOk = 1'b1;
      for (int d = 0; d < 4; d++) if (int'(pin[4*d +: 4]) != c) pinOk = 1'b0;
      if (pinOk) begin
        modelSession  = c;
        modelFails[c] = 0;
      end else begin
        st = 3'd2;
        modelFails[c]++;
        if (modelFails[c] >= 3) modelLock[c] = 1'b1;
      end
    end
    else if (modelSession != c) st = 3'd6;
    else if (op != 3'd1 && amount == 32'd0) st = 3'd7;
    else if (op == 3'd1) bal = 32'(modelBal[c]);
    else if (op == 3'd2) begin
      if (modelBal[c] + longint'(amount) > 64'hFFFF_FFFF) begin
        st  = 3'd5;
        bal = 32'(modelBal[c]);
      end else begin
        modelBal[c] += longint'(amount);
        bal = 32'(modelBal[c]);
      end
    end else begin
      if (longint'(amount) > modelBal[c]) begin
        st  = 3'd4;
        bal = 32'(modelBal[c]);
      end else begin
        modelBal[c] -= longint'(amount);
        bal = 32'(modelBal[c]);
      end
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
  endtask

  // One full transaction with response latency, content, hold-stability and release checks.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] card, input logic [15:0] pin,
                               input logic [31:0] amount, input int hold,
                               output logic [2:0] obsStatus, output logic [31:0] obsBal);
    int cyc;
    logic [2:0]  expSt;
    logic [31:0] expBal;
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("req_ready before request", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_card   = card;
    bus.req_pin    = pin;
    bus.req_amount = amount;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'($urandom);
    bus.req_card   = 4'($urandom);
    bus.req_pin    = 16'($urandom);
    bus.req_amount = $urandom;
    modelStep(op, card, pin, amount, expSt, expBal);
    cyc = 0;
    while (!bus.rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("rsp latency", 32'(cyc), 32'd2);
    obsStatus = bus.rsp_status;
    obsBal    = bus.rsp_balance;
    checkOutput("rsp_status", 32'(obsStatus), 32'(expSt));
    checkOutput("rsp_balance", obsBal, expBal);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checkOutput("held rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("held rsp_status", 32'(bus.rsp_status), 32'(expSt));
      checkOutput("held rsp_balance", bus.rsp_balance, expBal);
      checkOutput("held req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checkOutput("rsp_valid released", 32'(bus.rsp_valid), 32'd0);
    checkOutput("req_ready released", 32'(bus.req_ready), 32'd1);
  endtask

  logic [2:0]  st;
  logic [31:0] bal;

  initial begin
    int cyc;
    logic [3:0]  rc;
    logic [2:0]  rop;
    logic [15:0] rpin;
    logic [31:0] ramt;
    int          r;

    $display("[TB] starting");
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_card   = '0;
    bus.req_pin    = '0;
    bus.req_amount = '0;
    bus.rsp_ready  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset rsp_status", 32'(bus.rsp_status), 32'd0);
    checkOutput("reset rsp_balance", bus.rsp_balance, 32'd0);

    applyStimulus(3'd0, 4'd3, 16'h3333, 32'd0, 0, st, bal);
    checkOutput("verify3 ok", 32'(st), 32'd0);
    applyStimulus(3'd1, 4'd3, 16'h0000, 32'd0, 0, st, bal);
    checkOutput("balance3 value", bal, 32'd3333);

    applyStimulus(3'd0, 4'd2, 16'h2222, 32'd0, 0, st, bal);
    applyStimulus(3'd2, 4'd2, 16'h0000, 32'd100, 0, st, bal);
    checkOutput("deposit2 value", bal, 32'd2322);
    applyStimulus(3'd3, 4'd2, 16'h0000, 32'd2322, 0, st, bal);
    checkOutput("withdraw all value", bal, 32'd0);
    applyStimulus(3'd3, 4'd2, 16'h0000, 32'd1, 0, st, bal);
    checkOutput("withdraw no funds", 32'(st), 32'd4);
    applyStimulus(3'd2, 4'd2, 16'h0000, 32'd0, 0, st, bal);
    checkOutput("deposit zero", 32'(st), 32'd7);

    for (int t = 0; t < 3; t++) applyStimulus(3'd0, 4'd4, 16'h0000, 32'd0, 0, st, bal);
    applyStimulus(3'd0, 4'd4, 16'h4444, 32'd0, 0, st, bal);
    checkOutput("card4 locked", 32'(st), 32'd3);
    doReset();
    applyStimulus(3'd0, 4'd4, 16'h4444, 32'd0, 0, st, bal);
    checkOutput("card4 after reset", 32'(st), 32'd0);

    applyStimulus(3'd1, 4'd1, 16'h0000, 32'd0, 0, st, bal);
    applyStimulus(3'd0, 4'd1, 16'h1111, 32'd0, 0, st, bal);
    applyStimulus(3'd4, 4'd1, 16'h0000, 32'd0, 0, st, bal);
    applyStimulus(3'd1, 4'd1, 16'h0000, 32'd0, 0, st, bal);
    checkOutput("balance after logout", 32'(st), 32'd6);

    applyStimulus(3'd0, 4'd0, 16'h0000, 32'd0, 0, st, bal);
    applyStimulus(3'd0, 4'd7, 16'h7777, 32'd0, 0, st, bal);
    applyStimulus(3'd5, 4'd1, 16'h1111, 32'd0, 0, st, bal);

    applyStimulus(3'd0, 4'd5, 16'h5555, 32'd0, 0, st, bal);
    applyStimulus(3'd2, 4'd5, 16'h0000, 32'hFFFF_FFF0 - 32'd5555, 0, st, bal);
    applyStimulus(3'd2, 4'd5, 16'h0000, 32'h20, 0, st, bal);
    checkOutput("overflow balance", bal, 32'hFFFF_FFF0);

    applyStimulus(3'd1, 4'd5, 16'h0000, 32'd0, 5, st, bal);

    // Reset lands on the commit edge of a deposit; the deposit must vanish.
    applyStimulus(3'd0, 4'd3, 16'h3333, 32'd0, 0, st, bal);
    bus.req_valid  = 1'b1;
    bus.req_op     = 3'd2;
    bus.req_card   = 4'd3;
    bus.req_amount = 32'd500;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    checkOutput("reset in exec rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset in exec req_ready", 32'(bus.req_ready), 32'd1);
    applyStimulus(3'd0, 4'd3, 16'h3333, 32'd0, 0, st, bal);
    applyStimulus(3'd1, 4'd3, 16'h0000, 32'd0, 0, st, bal);
    checkOutput("card3 after exec reset", bal, 32'd3333);

    for (int n = 0; n < 300; n++) begin
      if (n % 60 == 59) doReset();
      r  = int'($urandom_range(0, 99));
      rc = (r < 90) ? 4'($urandom_range(1, 5)) : 4'($urandom_range(0, 15));
      r  = int'($urandom_range(0, 99));
      if (r < 30) rop = 3'd0;
      else if (r < 45) rop = 3'd1;
      else if (r < 65) rop = 3'd2;
      else if (r < 85) rop = 3'd3;
      else if (r < 95) rop = 3'd4;
      else rop = 3'($urandom_range(5, 7));
      rpin = ($urandom_range(0, 99) < 80) ? {4{rc}} : 16'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 10) ramt = 32'd0;
      else if (r < 20) ramt = $urandom;
      else ramt = 32'($urandom_range(1, 5000));
      applyStimulus(rop, rc, rpin, ramt, int'($urandom_range(0, 2)), st, bal);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
